// File: rtl/irq_ctrl_pkg.sv
// Shared types and default sizing for the interrupt source controller.
package irq_pkg;

  localparam int unsigned NUM_SRC_DEF   = 8;
  localparam int unsigned VEC_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Program-sequencer side of the interrupt controller: mask writes, ack/rti
// strobes, and the registered request/status outputs.
interface irq_ctrl_if
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
  parameter int unsigned VEC_WIDTH = VEC_WIDTH_DEF
);

  logic                 ps_mask_wr;
  logic [NUM_SRC-1:0]   ps_mask_dt;
  logic                 ps_irq_ack;
  logic                 ps_irq_rti;
  logic                 interrupt;
  logic [VEC_WIDTH-1:0] irq_vec;
  logic                 irq_active;
  logic [NUM_SRC-1:0]   irq_pend;
  logic [NUM_SRC-1:0]   irq_mask;

  modport master (
    output ps_mask_wr, ps_mask_dt, ps_irq_ack, ps_irq_rti,
    input  interrupt, irq_vec, irq_active, irq_pend, irq_mask
  );

  modport slave (
    input  ps_mask_wr, ps_mask_dt, ps_irq_ack, ps_irq_rti,
    output interrupt, irq_vec, irq_active, irq_pend, irq_mask
  );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational find-first-set: index 0 is the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
  parameter int unsigned VEC_WIDTH = VEC_WIDTH_DEF
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic [VEC_WIDTH-1:0] vec,
  output logic                 valid
);

  always_comb begin
    vec   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        vec   = VEC_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt source controller: edge-detects sources into a pending latch, masks,
// prioritises and holds a single registered request until acked, then blocks until rti.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC   = NUM_SRC_DEF,
  parameter int unsigned VEC_WIDTH = VEC_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  irq_ctrl_if.slave          bus
);

  irq_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   src_q, src_d;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [VEC_WIDTH-1:0] vec_q, vec_d;
  logic                 interrupt_q, interrupt_d;
  logic                 active_q, active_d;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   eligible;
  logic [VEC_WIDTH-1:0] enc_vec;
  logic                 enc_valid;

  assign rise     = irq_src & ~src_q;
  assign eligible = pend_q & mask_q;

  irq_prio_enc #(
    .NUM_SRC   (NUM_SRC),
    .VEC_WIDTH (VEC_WIDTH)
  ) u_prio_enc (
    .req   (eligible),
    .vec   (enc_vec),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pend_d  = pend_q;
    src_d   = irq_src;
    mask_d  = bus.ps_mask_wr ? bus.ps_mask_dt : mask_q;

    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = REQ;
          vec_d   = enc_vec;
        end
      end
      REQ: begin
        // Ack is checked against the current mask, so a same-cycle mask write cannot cancel it.
        if (bus.ps_irq_ack) begin
          state_d        = SERVICE;
          pend_d[vec_q]  = 1'b0;
        end else if (!mask_q[vec_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.ps_irq_rti) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the acked source wins over the clear.
    pend_d      = pend_d | rise;
    interrupt_d = (state_d == REQ);
    active_d    = (state_d == SERVICE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      vec_q       <= '0;
      interrupt_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      vec_q       <= vec_d;
      interrupt_q <= interrupt_d;
      active_q    <= active_d;
    end
  end

  assign bus.interrupt  = interrupt_q;
  assign bus.irq_vec    = vec_q;
  assign bus.irq_active = active_q;
  assign bus.irq_pend   = pend_q;
  assign bus.irq_mask   = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model.
module tb_irq_ctrl;

  localparam int unsigned NS = 8;
  localparam int unsigned VW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] src;

  irq_ctrl_if #(.NUM_SRC(NS), .VEC_WIDTH(VW)) ifc ();

  irq_ctrl #(.NUM_SRC(NS), .VEC_WIDTH(VW)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .irq_src (src),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 = waiting, 1 = requesting, 2 = in service.
  int       m_mode = 0;
  int       m_vec  = 0;
  bit [7:0] m_pend = '0;
  bit [7:0] m_mask = '0;
  bit [7:0] m_src  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    bit [7:0] iso;
    iso = v & (~v + 8'd1);
    return $clog2(iso);
  endfunction

  task automatic model_edge();
    bit [7:0] rise;
    bit [7:0] elig;
    bit [7:0] np;
    if (!rst_n) begin
      m_mode = 0; m_vec = 0; m_pend = '0; m_mask = '0; m_src = '0;
    end else begin
      rise = src & ~m_src;
      elig = m_pend & m_mask;
      np   = m_pend;
      if (m_mode == 0) begin
        if (elig != 0) begin m_mode = 1; m_vec = lowest(elig); end
      end else if (m_mode == 1) begin
        if (ifc.ps_irq_ack) begin m_mode = 2; np[m_vec] = 1'b0; end
        else if (!m_mask[m_vec]) m_mode = 0;
      end else begin
        if (ifc.ps_irq_rti) m_mode = 0;
      end
      m_pend = np | rise;
      if (ifc.ps_mask_wr) m_mask = ifc.ps_mask_dt;
      m_src = src;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("interrupt",  32'(ifc.interrupt),  32'(m_mode == 1));
    chk("irq_active", 32'(ifc.irq_active), 32'(m_mode == 2));
    chk("irq_vec",    32'(ifc.irq_vec),    32'(m_vec));
    chk("irq_pend",   32'(ifc.irq_pend),   32'(m_pend));
    chk("irq_mask",   32'(ifc.irq_mask),   32'(m_mask));
  endtask

  task automatic set_mask(input logic [7:0] v);
    ifc.ps_mask_wr = 1'b1; ifc.ps_mask_dt = v;
    step();
    ifc.ps_mask_wr = 1'b0;
  endtask

  task automatic do_ack();
    ifc.ps_irq_ack = 1'b1; step(); ifc.ps_irq_ack = 1'b0;
  endtask

  task automatic do_rti();
    ifc.ps_irq_rti = 1'b1; step(); ifc.ps_irq_rti = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    src = v; step(); src = '0;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; src = '0;
    ifc.ps_mask_wr = 1'b0; ifc.ps_mask_dt = '0;
    ifc.ps_irq_ack = 1'b0; ifc.ps_irq_rti = 1'b0;
    repeat (3) step();
    chk("rst_interrupt", 32'(ifc.interrupt), 0);
    chk("rst_pend",      32'(ifc.irq_pend),  0);
    rst_n = 1'b1;

    // 1: single source, two-cycle latency, ack clears pend.
    set_mask(8'hFF);
    pulse_src(8'h20);
    chk("t1_no_int_yet", 32'(ifc.interrupt), 0);
    step();
    chk("t1_int", 32'(ifc.interrupt), 1);
    chk("t1_vec", 32'(ifc.irq_vec), 5);
    do_ack();
    chk("t1_active", 32'(ifc.irq_active), 1);
    chk("t1_pend5",  32'(ifc.irq_pend[5]), 0);
    do_rti();

    // 2: priority, then second request after rti.
    pulse_src(8'h44);
    step();
    chk("t2_vec2", 32'(ifc.irq_vec), 2);
    do_ack();
    do_rti();
    chk("t2_idle", 32'(ifc.interrupt), 0);
    step();
    chk("t2_vec6", 32'(ifc.irq_vec), 6);
    chk("t2_int6", 32'(ifc.interrupt), 1);
    do_ack();
    do_rti();

    // 3: masked pend, then unmask.
    set_mask(8'h00);
    pulse_src(8'h08);
    step();
    chk("t3_masked_int", 32'(ifc.interrupt), 0);
    chk("t3_pend",       32'(ifc.irq_pend), 32'h08);
    set_mask(8'h08);
    step();
    chk("t3_int", 32'(ifc.interrupt), 1);
    chk("t3_vec", 32'(ifc.irq_vec), 3);
    do_ack();
    do_rti();

    // 4: mask removed mid-request, stray ack in idle.
    set_mask(8'hFF);
    pulse_src(8'h10);
    step();
    chk("t4_vec4", 32'(ifc.irq_vec), 4);
    set_mask(8'h00);
    step();
    chk("t4_dropped", 32'(ifc.interrupt), 0);
    chk("t4_pend",    32'(ifc.irq_pend), 32'h10);
    do_ack();
    chk("t4_stray_ack_pend",   32'(ifc.irq_pend), 32'h10);
    chk("t4_stray_ack_active", 32'(ifc.irq_active), 0);
    set_mask(8'hFF);
    step();
    do_ack();
    do_rti();

    // 5: ack coincides with a new edge on the same source.
    pulse_src(8'h02);
    step();
    chk("t5_vec1", 32'(ifc.irq_vec), 1);
    src = 8'h02; ifc.ps_irq_ack = 1'b1;
    step();
    src = '0; ifc.ps_irq_ack = 1'b0;
    chk("t5_active", 32'(ifc.irq_active), 1);
    chk("t5_pend1",  32'(ifc.irq_pend[1]), 1);
    do_rti();
    step();
    chk("t5_rereq", 32'(ifc.interrupt), 1);
    chk("t5_vec",   32'(ifc.irq_vec), 1);
    do_ack();
    do_rti();

    // 6: held level gives one request; reset during service.
    src = 8'h01;
    step(); step();
    chk("t6_vec0", 32'(ifc.irq_vec), 0);
    chk("t6_int",  32'(ifc.interrupt), 1);
    do_ack();
    do_rti();
    seen = 0;
    repeat (16) begin
      step();
      if (ifc.interrupt) seen++;
    end
    chk("t6_no_rereq", 32'(seen), 0);
    src = '0;
    pulse_src(8'h88);
    step();
    chk("t6_vec3", 32'(ifc.irq_vec), 3);
    do_ack();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_int",    32'(ifc.interrupt), 0);
    chk("t6_rst_active", 32'(ifc.irq_active), 0);
    chk("t6_rst_vec",    32'(ifc.irq_vec), 0);
    chk("t6_rst_pend",   32'(ifc.irq_pend), 0);

    // Randomized traffic.
    for (int unsigned c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int unsigned b = 0; b < NS; b++)
        if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      ifc.ps_mask_wr = ($urandom_range(0, 15) == 0);
      ifc.ps_mask_dt = 8'($urandom) | 8'($urandom);
      ifc.ps_irq_ack = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      ifc.ps_irq_rti = (m_mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
